// File: rtl/main_mem_pkg.sv
// Shared widths, FSM state encoding and address/initialisation helpers for
// the main-memory back end of the two-way write-back data cache.
`timescale 1ns/1ps
package main_mem_pkg;

  localparam int ADDR_W          = 10;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int NUM_BLOCKS      = 64;
  localparam int IDX_W           = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W        = $clog2(BLOCK_W / 8);
  localparam int CNT_W           = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Byte address to block index; the in-block byte offset is dropped.
  function automatic logic [IDX_W-1:0] block_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFFSET_W);
  endfunction

  // Power-up content: word w holds the value w, so block b = {4b+3 .. 4b}.
  function automatic logic [BLOCK_W-1:0] init_block(input logic [IDX_W-1:0] idx);
    logic [BLOCK_W-1:0] blk;
    blk = '0;
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      blk[w*WORD_W +: WORD_W] = WORD_W'(int'(idx) * WORDS_PER_BLOCK + w);
    end
    return blk;
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// 64 x 128-bit single-port block storage: synchronous write, combinational read,
// power-up content given by init_block() until a block is first written.
`timescale 1ns/1ps
module main_mem_array
  import main_mem_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   idx,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  logic [BLOCK_W-1:0]    mem [NUM_BLOCKS];
  // 2-state flags power up at zero, so an unwritten block reads its init pattern.
  bit   [NUM_BLOCKS-1:0] written;

  // NOTE: storage has no reset; a controller reset must leave memory contents intact.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx]     <= wdata;
      written[idx] <= 1'b1;
    end
  end

  assign rdata = written[idx] ? mem[idx] : init_block(idx);

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: one 128-bit block fill or write-back at a time with a
// fixed LATENCY. Define MAIN_MEM_STATS_EN to add rd_count/wr_count ports.
`timescale 1ns/1ps
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_rdata
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic               lat_write;
  logic [BLOCK_W-1:0] lat_wdata;
  logic [BLOCK_W-1:0] arr_rdata;
  logic               access;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // The access happens on the last BUSY edge; decoding it from state means a
  // reset aborts a pending write without touching the array.
  assign access     = (state == BUSY) && (cnt == '0);

  main_mem_array u_array (
    .clk   (clk),
    .we    (access && lat_write),
    .idx   (lat_idx),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_idx    <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_idx   <= block_idx(req_addr);
            lat_write <= req_write;
            lat_wdata <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_rdata <= lat_write ? lat_wdata : arr_rdata;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access) begin
      if (lat_write) wr_count <= wr_count + 16'd1;
      else           rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: a LATENCY=4 and a LATENCY=1 instance
// share stimulus via a select line and are checked against a block-array model.
`timescale 1ns/1ps
module tb_main_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset     = 1'b1;
  logic         sel       = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [9:0]   req_addr  = '0;
  logic [127:0] req_wdata = '0;

  logic         rv_in4, rv_in1;
  logic         ready4, ready1, rv4, rv1;
  logic [127:0] rdata4, rdata1;
  logic         rdy, rv;
  logic [127:0] rdata;

  assign rv_in4 = req_valid & ~sel;
  assign rv_in1 = req_valid & sel;
  assign rdy    = sel ? ready1 : ready4;
  assign rv     = sel ? rv1 : rv4;
  assign rdata  = sel ? rdata1 : rdata4;

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] rdc4, wrc4, rdc1, wrc1, rdc, wrc;
  assign rdc = sel ? rdc1 : rdc4;
  assign wrc = sel ? wrc1 : wrc4;
`endif

  main_mem_ctrl #(.LATENCY(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (rv_in4),
    .req_ready  (ready4),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (rv4),
    .resp_rdata (rdata4)
`ifdef MAIN_MEM_STATS_EN
    ,
    .rd_count   (rdc4),
    .wr_count   (wrc4)
`endif
  );

  main_mem_ctrl #(.LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (rv_in1),
    .req_ready  (ready1),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (rv1),
    .resp_rdata (rdata1)
`ifdef MAIN_MEM_STATS_EN
    ,
    .rd_count   (rdc1),
    .wr_count   (wrc1)
`endif
  );

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  logic [127:0] mdl [2][64];
  int           exp_rd [2];
  int           exp_wr [2];

  always @(negedge clk) begin
    if (rv4) pulses++;
    if (rv1) pulses++;
  end

  function automatic logic [127:0] init_blk(input int b);
    return {32'(4*b + 3), 32'(4*b + 2), 32'(4*b + 1), 32'(4*b)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef MAIN_MEM_STATS_EN
    int s;
    s = sel ? 1 : 0;
    check("rd_count", 128'(rdc), 128'(16'(exp_rd[s])));
    check("wr_count", 128'(wrc), 128'(16'(exp_wr[s])));
`endif
  endtask

  // One transfer on the selected instance, starting and ending on a negedge in IDLE.
  // With hold set, req_valid stays high during BUSY carrying a read of hold_addr.
  task automatic xfer(input logic w, input logic [9:0] a, input logic [127:0] d,
                      input bit hold, input logic [9:0] hold_addr);
    int s, b, lat, n;
    logic [127:0] exp_d;
    s   = sel ? 1 : 0;
    b   = int'(a[9:4]);
    lat = sel ? 1 : 4;
    n   = 0;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_idle", 128'(rdy), 128'(1));
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    check("ready_busy", 128'(rdy), 128'(0));
    if (hold) begin
      req_write = 1'b0;
      req_addr  = hold_addr;
      req_wdata = {4{$urandom}};
    end else begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 10'($urandom);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    n = 0;
    while (rv !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 128'(n), 128'(lat));
    exp_d = w ? d : mdl[s][b];
    if (w) begin
      mdl[s][b] = d;
      exp_wr[s]++;
    end else begin
      exp_rd[s]++;
    end
    check("rdata", rdata, exp_d);
    check("ready_resp", 128'(rdy), 128'(0));
    check_stats();
    @(negedge clk);
    check("valid_pulse", 128'(rv), 128'(0));
    check("ready_back", 128'(rdy), 128'(1));
    check("rdata_hold", rdata, exp_d);
  endtask

  initial begin
    int p0;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = 0;
      exp_wr[s] = 0;
      for (int b = 0; b < 64; b++) mdl[s][b] = init_blk(b);
    end

    // Reset state on both instances.
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_ready", 128'(rdy), 128'(1));
      check("rst_valid", 128'(rv), 128'(0));
      check("rst_rdata", rdata, 128'(0));
      check_stats();
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // LATENCY=4 read of block 2.
    xfer(1'b0, 10'h020, '0, 1'b0, '0);
    check("blk2_const", rdata, 128'h0000000B_0000000A_00000009_00000008);

    // Write block 5 then read it back.
    xfer(1'b1, 10'h05C, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 1'b0, '0);
    xfer(1'b0, 10'h050, '0, 1'b0, '0);
    check("raw_const", rdata, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);

    // Request held through BUSY: second request only taken in IDLE.
    p0 = pulses;
    xfer(1'b0, 10'h0A4, '0, 1'b1, 10'h0C8);
    xfer(1'b0, 10'h0C8, '0, 1'b0, '0);
    repeat (6) @(negedge clk);
    check("two_pulses", 128'(pulses - p0), 128'(2));

    // LATENCY=1, top block, byte offset ignored.
    sel = 1'b1;
    @(negedge clk);
    xfer(1'b0, 10'h3F0, '0, 1'b0, '0);
    check("blk63_const", rdata, 128'h000000FF_000000FE_000000FD_000000FC);
    xfer(1'b0, 10'h3FF, '0, 1'b0, '0);
    check("blk63_off", rdata, 128'h000000FF_000000FE_000000FD_000000FC);
    xfer(1'b1, 10'h104, {4{32'h5A5A_0001}}, 1'b0, '0);
    xfer(1'b0, 10'h10C, '0, 1'b0, '0);

    // Reset two cycles into a write of block 7 aborts it.
    sel = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'h070;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b0;
    p0 = pulses;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = 0;
      exp_wr[s] = 0;
    end
    check("abort_valid", 128'(rv), 128'(0));
    check("abort_ready", 128'(rdy), 128'(1));
    check("abort_rdata", rdata, 128'(0));
    check_stats();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_nopulse", 128'(pulses - p0), 128'(0));
    xfer(1'b0, 10'h070, '0, 1'b0, '0);
    check("blk7_init", rdata, 128'h0000001F_0000001E_0000001D_0000001C);

    // Randomized traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      xfer(1'($urandom_range(0, 1)), 10'($urandom), {$urandom, $urandom, $urandom, $urandom},
           1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
Clocked main-memory back end for the two-way write-back data cache. It serves one 128-bit block transfer at a time: line fills on a miss and dirty-victim write-backs.
- A valid/ready request handshake and a fixed, parameterised access latency replace the cache's current zero-time memory model.
- The block sits directly downstream of the cache miss/eviction path.

Parameters:
ADDR_W, 10, byte-address width from the cache
BLOCK_W, 128, block width (4 words of 32 bits)
LATENCY, 4, cycles from request acceptance to response (legal range 1 to 15)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  0 = block read (fill), 1 = block write (write-back)
req_addr  input  ADDR_W  byte address; [9:4] is the block index, [3:0] is ignored
req_wdata  input  BLOCK_W  write-back block; word0 in [31:0], word3 in [127:96]
resp_valid  output  1  one-cycle pulse when the access completes
resp_rdata  output  BLOCK_W  read block; for a write, echoes the block just written

Behaviour:
- Storage: 64 blocks x 128 bits (1 KiB).
  - Initialised at time zero only: word w (w = 0..255) = 32'h0000_0000 + w.
  - Block b = {4b+3, 4b+2, 4b+1, 4b}.
  - reset never re-initialises or clears the storage.
- Reset (asynchronous, active-high):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, latency counter = 0.
  - Any in-flight access is aborted. A pending write is discarded and the array is unchanged.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready at an edge:
    - latch block index, req_write and req_wdata;
    - counter = LATENCY-1;
    - go to BUSY.
  - BUSY: req_ready = 0.
    - If counter != 0, decrement it.
    - If counter == 0, perform the access at this edge and go to RESP.
      - Read: resp_rdata = array[idx].
      - Write: array[idx] = latched data and resp_rdata = latched data.
  - RESP: resp_valid = 1 and req_ready = 0 for exactly one cycle, then IDLE.
- Timing:
  - Acceptance at edge 0 gives resp_valid high in the cycle after edge LATENCY.
  - Peak throughput is one request per LATENCY+1 cycles.
- Request inputs are sampled only at acceptance. Changes while in BUSY or RESP have no effect.
- req_valid while req_ready = 0 is ignored, with no queuing. The requester must hold its request until it sees req_ready.
- resp_rdata holds its value until the next completed access.
- Read-after-write to the same block (back-to-back requests) returns the newly written data.
- resp_valid never asserts without a preceding accepted request.

Optional Feature:
MAIN_MEM_STATS_EN.
- When defined, adds two ports:
  - rd_count output 16: completed reads.
  - wr_count output 16: completed writes.
- Each counter increments at the edge the access is performed. Both wrap from 16'hFFFF to 0 and clear on reset.
- An aborted access is not counted.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Package main_mem_pkg holds:
  - ADDR_W, WORD_W = 32, BLOCK_W, WORDS_PER_BLOCK = 4, NUM_BLOCKS = 64;
  - the state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2);
  - the block-index slice helper.
- One sub-module: main_mem_array.
  - 64 x 128 synchronous single-port storage with the time-zero init pattern.
  - Write enable and read are driven from the FSM.

Test Plan:
- Reset released, LATENCY = 4; read at addr 10'h020 accepted at edge 0 -> resp_valid pulses after edge 4 with resp_rdata = 128'h00000003_00000002_00000001_00000000 + {32'h8,32'h8,32'h8,32'h8} (block 2 = words 8..11); req_ready returns to 1 one cycle later.
- Write block 5 (addr 10'h05C) with data 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, then read addr 10'h050 -> read returns the written block; write resp_rdata echoes the same value.
- Hold req_valid while BUSY with a different address -> ignored; the second request is accepted only in IDLE, and exactly two resp_valid pulses occur.
- Assert reset two cycles into a write to block 7 -> no resp_valid; a subsequent read of block 7 returns the init pattern {32'h1F,32'h1E,32'h1D,32'h1C}.
- LATENCY = 1: read at addr 10'h3F0 -> resp_valid in the cycle after edge 1, data {32'hFF,32'hFE,32'hFD,32'hFC}; req_addr[3:0] = 4'hF gives the same result.
- MAIN_MEM_STATS_EN defined: 3 reads and 2 writes, plus one write aborted by reset -> rd_count = 0 and wr_count = 0 after reset. Without the mid-run reset: rd_count = 3, wr_count = 2.
